// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, started by Run,
// result and flags held registered in FIN until the next accepted Run.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Run,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             Div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH:0]   p_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] d_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             busy_r;
  logic             done_r;
  logic             dbz_r;

  logic [WIDTH:0]   p_sh_s;
  logic [WIDTH:0]   t_s;
  logic             ge_s;
  logic [WIDTH:0]   p_nx_s;
  logic [WIDTH-1:0] q_nx_s;
  logic             last_s;
  logic             accept_s;
  logic             dz_s;

  // One restoring step: shift {P,Q}, trial-subtract D via inverted operand plus carry-in.
  always_comb begin
    p_sh_s = {p_r[WIDTH-1:0], q_r[WIDTH-1]};
    t_s    = p_sh_s + ~{1'b0, d_r} + {{WIDTH{1'b0}}, 1'b1};
    ge_s   = ~t_s[WIDTH];
    if (ge_s) begin
      p_nx_s = t_s;
    end else begin
      p_nx_s = p_sh_s;
    end
    q_nx_s = {q_r[WIDTH-2:0], ge_s};
  end

  // Start/termination decode shared by the state register.
  always_comb begin
    last_s   = (cnt_r == CNT_LAST);
    accept_s = Run && ((state_r == IDLE) || (state_r == FIN));
    dz_s     = (Divisor == {WIDTH{1'b0}});
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r     <= IDLE;
      p_r         <= {(WIDTH+1){1'b0}};
      q_r         <= {WIDTH{1'b0}};
      d_r         <= {WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      dbz_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE, FIN: begin
          if (accept_s) begin
            // A zero divisor completes on the accept edge and never raises Busy.
            if (dz_s) begin
              quotient_r  <= {WIDTH{1'b1}};
              remainder_r <= Dividend;
              dbz_r       <= 1'b1;
              done_r      <= 1'b1;
              busy_r      <= 1'b0;
              state_r     <= FIN;
            end else begin
              p_r     <= {(WIDTH+1){1'b0}};
              q_r     <= Dividend;
              d_r     <= Divisor;
              cnt_r   <= {CW{1'b0}};
              dbz_r   <= 1'b0;
              done_r  <= 1'b0;
              busy_r  <= 1'b1;
              state_r <= CALC;
            end
          end else begin
            state_r <= state_r;
          end
        end
        CALC: begin
          p_r   <= p_nx_s;
          q_r   <= q_nx_s;
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (last_s) begin
            quotient_r  <= q_nx_s;
            remainder_r <= p_nx_s[WIDTH-1:0];
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            state_r     <= FIN;
          end else begin
            state_r <= CALC;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          dbz_r   <= 1'b0;
        end
      endcase
    end
  end

  assign Quotient    = quotient_r;
  assign Remainder   = remainder_r;
  assign Busy        = busy_r;
  assign Done        = done_r;
  assign Div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases then a Run-held random sweep
// against plain-arithmetic expectations.
module tb_seq_divider;
  localparam int W = 8;

  logic         Clk;
  logic         Reset_n;
  logic         Run;
  logic [W-1:0] Dividend;
  logic [W-1:0] Divisor;
  logic [W-1:0] Quotient;
  logic [W-1:0] Remainder;
  logic         Busy;
  logic         Done;
  logic         Div_by_zero;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  seq_divider #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Dividend(Dividend), .Divisor(Divisor),
    .Quotient(Quotient), .Remainder(Remainder), .Busy(Busy), .Done(Done),
    .Div_by_zero(Div_by_zero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_q"}, 32'(Quotient), 32'd0);
    chk({tag, "_r"}, 32'(Remainder), 32'd0);
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
    chk({tag, "_done"}, 32'(Done), 32'd0);
    chk({tag, "_dbz"}, 32'(Div_by_zero), 32'd0);
  endtask

  // Runs one operation; inj>0 pulses Run with 50/5 before busy edge inj; hold keeps Run high.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int inj, input bit hold);
    int eq, er, cyc;
    if (b == 0) begin
      eq = (1 << W) - 1;
      er = int'(a);
    end else begin
      eq = int'(a) / int'(b);
      er = int'(a) % int'(b);
    end
    @(negedge Clk);
    Dividend = a;
    Divisor  = b;
    Run      = 1'b1;
    @(posedge Clk);
    #1;
    cyc = 0;
    if (b == 0) begin
      chk({tag, "_dz_done"}, 32'(Done), 32'd1);
      chk({tag, "_dz_busy"}, 32'(Busy), 32'd0);
    end else begin
      chk({tag, "_start_busy"}, 32'(Busy), 32'd1);
      while (!Done && cyc < W + 4) begin
        @(negedge Clk);
        Run = hold || (cyc + 1 == inj);
        if (cyc + 1 == inj) begin
          Dividend = 8'd50;
          Divisor  = 8'd5;
        end else begin
          Dividend = W'($urandom);
          Divisor  = W'($urandom);
        end
        @(posedge Clk);
        #1;
        cyc++;
        if (Busy && Done) chk({tag, "_excl"}, 32'(Busy & Done), 32'd0);
      end
      chk({tag, "_latency"}, 32'(cyc), 32'(W));
      chk({tag, "_busy_end"}, 32'(Busy), 32'd0);
    end
    chk({tag, "_q"}, 32'(Quotient), 32'(eq));
    chk({tag, "_r"}, 32'(Remainder), 32'(er));
    chk({tag, "_dbz"}, 32'(Div_by_zero), 32'(b == 0));
    if (b != 0) begin
      chk({tag, "_inv"}, 32'(int'(Quotient) * int'(b) + int'(Remainder)), 32'(a));
      chk({tag, "_rlt"}, 32'(Remainder < b), 32'd1);
    end
    if (!hold) begin
      @(negedge Clk);
      Run = 1'b0;
    end
  endtask

  initial begin
    Reset_n  = 1'b0;
    Run      = 1'b0;
    Dividend = '0;
    Divisor  = '0;
    #12;
    chk_outputs_zero("reset");
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    chk_outputs_zero("post_reset");

    do_op("d100_7", 8'd100, 8'd7, 0, 1'b0);
    chk("d100_7_q_const", 32'(Quotient), 32'd14);
    chk("d100_7_r_const", 32'(Remainder), 32'd2);
    // Result must hold while idle in FIN.
    repeat (3) @(posedge Clk);
    #1;
    chk("hold_q", 32'(Quotient), 32'd14);
    chk("hold_done", 32'(Done), 32'd1);

    do_op("d255_1", 8'd255, 8'd1, 0, 1'b0);
    do_op("d5_200", 8'd5, 8'd200, 0, 1'b0);
    do_op("d255_255", 8'd255, 8'd255, 0, 1'b0);
    do_op("d0_9", 8'd0, 8'd9, 0, 1'b0);
    do_op("d37_0", 8'd37, 8'd0, 0, 1'b0);
    chk("d37_0_q_const", 32'(Quotient), 32'd255);
    do_op("d20_3", 8'd20, 8'd3, 0, 1'b0);
    chk("d20_3_q_const", 32'(Quotient), 32'd6);

    do_op("d200_9", 8'd200, 8'd9, 3, 1'b0);
    chk("d200_9_q_const", 32'(Quotient), 32'd22);
    do_op("d50_5", 8'd50, 8'd5, 0, 1'b0);
    chk("d50_5_q_const", 32'(Quotient), 32'd10);

    // Asynchronous reset mid-cycle during busy cycle 4.
    @(negedge Clk);
    Dividend = 8'd99;
    Divisor  = 8'd4;
    Run      = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Run = 1'b0;
    repeat (3) @(posedge Clk);
    #3;
    Reset_n = 1'b0;
    #1;
    chk_outputs_zero("mid_reset");
    @(negedge Clk);
    Reset_n = 1'b1;
    do_op("d99_4", 8'd99, 8'd4, 0, 1'b0);
    chk("d99_4_q_const", 32'(Quotient), 32'd24);
    chk("d99_4_r_const", 32'(Remainder), 32'd3);

    // Run held high: back-to-back operations with random operands and zero divisors.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
      do_op("rand", ra, rb, 0, 1'b1);
    end
    @(negedge Clk);
    Run = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
